// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose:
//   Bit-serial adder controller. One shared full_adder cell does all of the
//   arithmetic: it is fed one bit pair per clock, LSB first. Each accepted
//   start request produces a WIDTH-bit sum, a carry-out and a signed overflow
//   flag, and finishes with a single-cycle done pulse. This trades latency
//   for a very small datapath.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   n_rst     in   1      synchronous active-low reset
//   start     in   1      operation request, only looked at while idle
//   a, b      in   WIDTH  operands, captured when start is accepted
//   c_in      in   1      carry-in, captured when start is accepted
//   busy      out  1      high while bits are being added
//   done      out  1      one-cycle pulse when the result is ready
//   sum       out  WIDTH  result, held until the next accepted start
//   c_out     out  1      final carry-out, same validity as sum
//   overflow  out  1      signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------

// Single-bit full adder cell, the only arithmetic element in the design.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cOut_q;
  logic             overflow_q;

  logic             faSum;
  logic             faCarry;

  full_adder u_fa (
    .a_i (aSh_q[0]),
    .b_i (bSh_q[0]),
    .c_i (carry_q),
    .s_o (faSum),
    .c_o (faCarry)
  );

  // Controller FSM with all outputs registered alongside the state.
  // In ADD the operand shift registers present their LSB to the cell, the
  // cell's sum bit enters the result from the MSB side (so after WIDTH
  // shifts bit 0 has reached position 0) and the cell's carry is fed back.
  // On the last bit, carry_q still holds the carry into the MSB, so the
  // overflow flag is simply that carry XOR the cell's carry-out.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      sum_q      <= '0;
      bitCnt_q   <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cOut_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= ADD;
            busy_q   <= 1'b1;
            aSh_q    <= a;
            bSh_q    <= b;
            carry_q  <= c_in;
            bitCnt_q <= '0;
            sum_q    <= '0;
          end
        end

        ADD: begin
          sum_q    <= {faSum, sum_q[WIDTH-1:1]};
          aSh_q    <= aSh_q >> 1;
          bSh_q    <= bSh_q >> 1;
          carry_q  <= faCarry;
          bitCnt_q <= bitCnt_q + CNT_ONE;
          if (bitCnt_q == LAST_CNT) begin
            // Leaving ADD clears the counter so it never wraps.
            overflow_q <= carry_q ^ faCarry;
            cOut_q     <= faCarry;
            bitCnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = cOut_q;
  assign overflow = overflow_q;

endmodule
